// File: rtl/fir_poly_bank_mac_if.sv
// rtl/fir_poly_bank_mac_if.sv - sample, coefficient and result signals of one polyphase FIR bank
interface fir_poly_bank_mac_if #(
    parameter int INPUT_WIDTH  = 12,
    parameter int TAP_WIDTH    = 16,
    parameter int BANK_LEN     = 6,
    parameter int OUTPUT_WIDTH = 35
);
    localparam int ADDR_W = $clog2(BANK_LEN);

    logic signed [INPUT_WIDTH-1:0]  din;
    logic                           din_valid;
    logic                           din_ready;
    logic                           coef_we;
    logic [ADDR_W-1:0]              coef_addr;
    logic signed [TAP_WIDTH-1:0]    coef_data;
    logic signed [OUTPUT_WIDTH-1:0] dout;
    logic                           dout_valid;
    logic                           sat;
    logic                           overrun;

    modport master (
        output din, din_valid, coef_we, coef_addr, coef_data,
        input  din_ready, dout, dout_valid, sat, overrun
    );

    modport slave (
        input  din, din_valid, coef_we, coef_addr, coef_data,
        output din_ready, dout, dout_valid, sat, overrun
    );
endinterface

// File: rtl/fir_poly_bank_mac.sv
// rtl/fir_poly_bank_mac.sv - polyphase FIR branch: sample history, coefficient store, sequential MAC
module fir_poly_bank_mac #(
    parameter int INPUT_WIDTH  = 12,
    parameter int TAP_WIDTH    = 16,
    parameter int BANK_LEN     = 6,
    parameter int OUTPUT_WIDTH = 35,
    parameter int SHIFT        = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    fir_poly_bank_mac_if.slave     bank_if
);
    localparam int ACC_WIDTH = INPUT_WIDTH + TAP_WIDTH + $clog2(BANK_LEN);
    localparam int IDX_W     = $clog2(BANK_LEN);
    localparam int PROD_W    = INPUT_WIDTH + TAP_WIDTH;
    localparam int RND_W     = ACC_WIDTH + 1;
    localparam int EXT_W     = ((RND_W > OUTPUT_WIDTH) ? RND_W : OUTPUT_WIDTH) + 1;

    // One extra bit so the rounding bias can never wrap the accumulator
    localparam logic signed [RND_W-1:0] RND_BIAS =
        (SHIFT > 0) ? (RND_W'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [EXT_W-1:0] OUT_MAX = (EXT_W'(1) <<< (OUTPUT_WIDTH - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] OUT_MIN = -(EXT_W'(1) <<< (OUTPUT_WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                         state_q;
    logic                           ready_q;
    logic [IDX_W-1:0]               idx_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [INPUT_WIDTH-1:0]  hist_q [BANK_LEN];
    logic signed [TAP_WIDTH-1:0]    coef_q [BANK_LEN];
    logic signed [OUTPUT_WIDTH-1:0] dout_q;
    logic                           dout_valid_q;
    logic                           sat_q;
    logic                           overrun_q;

    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [RND_W-1:0]        rnd;
    logic signed [EXT_W-1:0]        rnd_ext;
    logic signed [OUTPUT_WIDTH-1:0] dout_d;
    logic                           sat_d;

    always_comb begin
        prod    = PROD_W'(coef_q[idx_q]) * PROD_W'(hist_q[idx_q]);
        acc_d   = acc_q + ACC_WIDTH'(prod);
        rnd     = (RND_W'(acc_q) + RND_BIAS) >>> SHIFT;
        rnd_ext = EXT_W'(rnd);
        sat_d   = 1'b0;
        dout_d  = rnd_ext[OUTPUT_WIDTH-1:0];
        if (rnd_ext > OUT_MAX) begin
            dout_d = OUT_MAX[OUTPUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end else if (rnd_ext < OUT_MIN) begin
            dout_d = OUT_MIN[OUTPUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            idx_q        <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < BANK_LEN; k++) begin
                hist_q[k] <= '0;
                coef_q[k] <= '0;
            end
        end else if (flush_i) begin
            // Coefficients, dout, sat and overrun survive a flush
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            idx_q        <= '0;
            acc_q        <= '0;
            dout_valid_q <= 1'b0;
            for (int k = 0; k < BANK_LEN; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            dout_valid_q <= 1'b0;
            if (bank_if.coef_we && (32'(bank_if.coef_addr) < 32'(BANK_LEN))) begin
                coef_q[bank_if.coef_addr] <= bank_if.coef_data;
            end
            if (bank_if.din_valid && !ready_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bank_if.din_valid) begin
                        hist_q[0] <= bank_if.din;
                        for (int k = 1; k < BANK_LEN; k++) begin
                            hist_q[k] <= hist_q[k-1];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_W'(BANK_LEN - 1)) begin
                        state_q <= S_OUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_OUT: begin
                    dout_q       <= dout_d;
                    sat_q        <= sat_d;
                    dout_valid_q <= 1'b1;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bank_if.din_ready  = ready_q;
    assign bank_if.dout       = dout_q;
    assign bank_if.dout_valid = dout_valid_q;
    assign bank_if.sat        = sat_q;
    assign bank_if.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_poly_bank_mac.sv
// tb/tb_fir_poly_bank_mac.sv - directed self-checking bench for fir_poly_bank_mac
module tb_fir_poly_bank_mac;
    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fir_poly_bank_mac_if #(.INPUT_WIDTH(12), .TAP_WIDTH(16), .BANK_LEN(4), .OUTPUT_WIDTH(35)) a_if ();
    fir_poly_bank_mac_if #(.INPUT_WIDTH(12), .TAP_WIDTH(16), .BANK_LEN(4), .OUTPUT_WIDTH(16)) b_if ();

    fir_poly_bank_mac #(.INPUT_WIDTH(12), .TAP_WIDTH(16), .BANK_LEN(4), .OUTPUT_WIDTH(35), .SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_a_n), .flush_i(flush_a), .bank_if(a_if.slave)
    );
    fir_poly_bank_mac #(.INPUT_WIDTH(12), .TAP_WIDTH(16), .BANK_LEN(4), .OUTPUT_WIDTH(16), .SHIFT(4)) u_b (
        .clk(clk), .rst_n(rst_b_n), .flush_i(flush_b), .bank_if(b_if.slave)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wca(input logic [1:0] addr, input logic signed [15:0] data);
        a_if.coef_we = 1'b1; a_if.coef_addr = addr; a_if.coef_data = data;
        step();
        a_if.coef_we = 1'b0;
    endtask

    task automatic wcb(input logic [1:0] addr, input logic signed [15:0] data);
        b_if.coef_we = 1'b1; b_if.coef_addr = addr; b_if.coef_data = data;
        step();
        b_if.coef_we = 1'b0;
    endtask

    task automatic run_a(input logic signed [11:0] s, output logic signed [63:0] d, output int lat);
        a_if.din = s; a_if.din_valid = 1'b1;
        step();
        a_if.din_valid = 1'b0;
        lat = 0;
        while (a_if.dout_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        d = a_if.dout;
    endtask

    task automatic run_b(input logic signed [11:0] s, output logic signed [63:0] d, output logic st);
        int lat;
        b_if.din = s; b_if.din_valid = 1'b1;
        step();
        b_if.din_valid = 1'b0;
        lat = 0;
        while (b_if.dout_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("b_latency", lat, 5);
        d  = b_if.dout;
        st = b_if.sat;
    endtask

    initial begin
        logic signed [63:0] d;
        logic               st;
        int                 lat;
        int                 seen;
        logic [12:0]        mask;
        logic signed [63:0] exp_imp [5];
        logic signed [11:0] smp_imp [5];
        logic signed [11:0] smp_rnd [4];
        logic signed [63:0] exp_rnd [4];

        exp_imp = '{64'sd1, 64'sd2, 64'sd3, 64'sd4, 64'sd0};
        smp_imp = '{12'sd1, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
        smp_rnd = '{12'sd8, 12'sd7, -12'sd8, -12'sd9};
        exp_rnd = '{64'sd1, 64'sd0, 64'sd0, -64'sd1};

        a_if.din = '0; a_if.din_valid = 1'b0; a_if.coef_we = 1'b0; a_if.coef_addr = '0; a_if.coef_data = '0;
        b_if.din = '0; b_if.din_valid = 1'b0; b_if.coef_we = 1'b0; b_if.coef_addr = '0; b_if.coef_data = '0;
        step();
        step();

        chk("rst_dout", a_if.dout, 0);
        chk("rst_dout_valid", a_if.dout_valid, 0);
        chk("rst_sat", a_if.sat, 0);
        chk("rst_overrun", a_if.overrun, 0);
        chk("rst_din_ready", a_if.din_ready, 1);
        chk("rst_b_dout", b_if.dout, 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step();

        // Impulse response with coef = {1,2,3,4}
        for (int k = 0; k < 4; k++) wca(2'(k), 16'(k + 1));
        for (int i = 0; i < 5; i++) begin
            run_a(smp_imp[i], d, lat);
            chk("imp_dout", d, exp_imp[i]);
            chk("imp_latency", lat, 5);
        end
        step();
        chk("dout_valid_pulse", a_if.dout_valid, 0);
        chk("imp_sat", a_if.sat, 0);

        // Flush in the 2nd MAC cycle, with a concurrent sample that must be dropped silently
        run_a(12'sd7, d, lat);
        chk("pre_flush_dout", d, 7);
        a_if.din = 12'sd3; a_if.din_valid = 1'b1;
        step();
        a_if.din_valid = 1'b0;
        step();
        flush_a = 1'b1; a_if.din = 12'sd11; a_if.din_valid = 1'b1;
        step();
        flush_a = 1'b0; a_if.din_valid = 1'b0;
        chk("flush_din_ready", a_if.din_ready, 1);
        chk("flush_no_overrun", a_if.overrun, 0);
        chk("flush_dout_kept", a_if.dout, 7);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_if.dout_valid === 1'b1) seen++;
            step();
        end
        chk("flush_no_dout_valid", seen, 0);
        run_a(12'sd5, d, lat);
        chk("post_flush_dout", d, 5);

        // Continuous din_valid: accepts only every 6th cycle, overrun becomes sticky
        chk("pre_stream_overrun", a_if.overrun, 0);
        a_if.din = '0; a_if.din_valid = 1'b1;
        mask = '0;
        for (int i = 0; i < 13; i++) begin
            mask[i] = a_if.din_ready;
            step();
            if (i == 1) chk("overrun_set", a_if.overrun, 1);
        end
        a_if.din_valid = 1'b0;
        chk("accept_pattern", mask, 13'b1000001000001);
        for (int i = 0; i < 8; i++) step();
        chk("overrun_sticky", a_if.overrun, 1);

        // Reset in the middle of MAC
        run_a(12'sd9, d, lat);
        chk("pre_reset_dout", d, 9);
        a_if.din = 12'sd2; a_if.din_valid = 1'b1;
        step();
        a_if.din_valid = 1'b0;
        step();
        rst_a_n = 1'b0;
        step();
        chk("mid_reset_dout", a_if.dout, 0);
        chk("mid_reset_dout_valid", a_if.dout_valid, 0);
        chk("mid_reset_din_ready", a_if.din_ready, 1);
        chk("mid_reset_overrun", a_if.overrun, 0);
        rst_a_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_if.dout_valid === 1'b1) seen++;
        end
        chk("reset_no_output", seen, 0);
        run_a(12'sd100, d, lat);
        chk("reset_coef_cleared", d, 0);
        chk("reset_latency", lat, 5);

        // Saturation on the 16-bit, SHIFT=4 bank
        for (int k = 0; k < 4; k++) wcb(2'(k), 16'sd32767);
        for (int i = 0; i < 4; i++) run_b(12'sd2047, d, st);
        chk("sat_pos_dout", d, 32767);
        chk("sat_pos_flag", st, 1);
        for (int i = 0; i < 4; i++) run_b(-12'sd2048, d, st);
        chk("sat_neg_dout", d, -32768);
        chk("sat_neg_flag", st, 1);

        // Round half toward +inf with coef = {1,0,0,0}
        wcb(2'd0, 16'sd1);
        for (int k = 1; k < 4; k++) wcb(2'(k), 16'sd0);
        for (int i = 0; i < 4; i++) begin
            run_b(smp_rnd[i], d, st);
            chk("round_dout", d, exp_rnd[i]);
            chk("round_sat", st, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end
endmodule
